// File: rtl/two_player_match_ctrl.sv
// Purpose: 2-player match sequencer - grace window, result latch, win-screen select, win counters, new-game pulse.
// Latency: all outputs registered; winSel/showResult valid 1 clk after the judging startOfFrame.
// Backpressure: none; keys are level inputs edge-detected here, frame timing comes only from startOfFrame.
module two_player_match_ctrl #(
    parameter int LIVES_W      = 4,
    parameter int GRACE_FRAMES = 15,
    parameter int SHOW_FRAMES  = 180,
    parameter int SCORE_MAX    = 9
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               startKey,
    input  logic               restartKey,
    input  logic               timeUp,
    input  logic [LIVES_W-1:0] lives,
    input  logic [LIVES_W-1:0] lives2,
    output logic               gameActive,
    output logic               showResult,
    output logic [2:0]         winSel,
    output logic [3:0]         p1Wins,
    output logic [3:0]         p2Wins,
    output logic               newGamePulse
);

    localparam int MAX_FRAMES = (GRACE_FRAMES > SHOW_FRAMES) ? GRACE_FRAMES : SHOW_FRAMES;
    localparam int CNT_W      = (MAX_FRAMES > 2) ? $clog2(MAX_FRAMES) : 1;

    localparam logic [CNT_W-1:0] GRACE_LAST = CNT_W'(GRACE_FRAMES - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_FRAMES - 1);
    localparam logic [3:0]       SCORE_SAT  = 4'(SCORE_MAX);

    localparam logic [2:0] SEL_NONE = 3'b000;
    localparam logic [2:0] SEL_P2   = 3'b001;
    localparam logic [2:0] SEL_P1   = 3'b010;
    localparam logic [2:0] SEL_DRAW = 3'b100;

    typedef enum logic [2:0] {
        IDLE,
        PLAYING,
        GRACE,
        RESULT,
        HOLD
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] frame_cnt;

    // Key edge detection. The armed flags stay low until a key has been seen
    // released after reset, so a key held through reset never fires.
    logic start_prev;
    logic restart_prev;
    logic start_armed;
    logic restart_armed;
    logic start_edge;
    logic restart_edge;

    assign start_edge   = startKey   & ~start_prev   & start_armed;
    assign restart_edge = restartKey & ~restart_prev & restart_armed;

    // Previous-value and armed registers for both keys
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            start_prev    <= 1'b0;
            restart_prev  <= 1'b0;
            start_armed   <= 1'b0;
            restart_armed <= 1'b0;
        end else begin
            start_prev    <= startKey;
            restart_prev  <= restartKey;
            start_armed   <= start_armed   | ~startKey;
            restart_armed <= restart_armed | ~restartKey;
        end
    end

    // Match FSM with registered outputs, frame counter and win counters
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= IDLE;
            frame_cnt    <= '0;
            gameActive   <= 1'b0;
            showResult   <= 1'b0;
            winSel       <= SEL_NONE;
            p1Wins       <= 4'd0;
            p2Wins       <= 4'd0;
            newGamePulse <= 1'b0;
        end else begin
            newGamePulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        state        <= PLAYING;
                        gameActive   <= 1'b1;
                        showResult   <= 1'b0;
                        winSel       <= SEL_NONE;
                        newGamePulse <= 1'b1;
                    end
                end

                PLAYING: begin
                    if ((lives == '0) || (lives2 == '0) || timeUp) begin
                        state     <= GRACE;
                        frame_cnt <= '0;
                    end
                end

                // Grace window runs to completion regardless of lives recovering;
                // only the lives values on the judging clock decide the winner.
                GRACE: begin
                    if (startOfFrame) begin
                        if (frame_cnt == GRACE_LAST) begin
                            state      <= RESULT;
                            frame_cnt  <= '0;
                            gameActive <= 1'b0;
                            showResult <= 1'b1;
                            if (lives2 > lives) begin
                                winSel <= SEL_P2;
                                if (p2Wins < SCORE_SAT) begin
                                    p2Wins <= p2Wins + 4'd1;
                                end
                            end else if (lives > lives2) begin
                                winSel <= SEL_P1;
                                if (p1Wins < SCORE_SAT) begin
                                    p1Wins <= p1Wins + 4'd1;
                                end
                            end else begin
                                winSel <= SEL_DRAW;
                            end
                        end else begin
                            frame_cnt <= frame_cnt + CNT_W'(1);
                        end
                    end
                end

                // Result screen is held for a minimum time; keys are ignored here.
                RESULT: begin
                    if (startOfFrame) begin
                        if (frame_cnt == SHOW_LAST) begin
                            state <= HOLD;
                        end else begin
                            frame_cnt <= frame_cnt + CNT_W'(1);
                        end
                    end
                end

                // Restart takes priority over a simultaneous start press.
                HOLD: begin
                    if (restart_edge) begin
                        state        <= PLAYING;
                        gameActive   <= 1'b1;
                        showResult   <= 1'b0;
                        winSel       <= SEL_NONE;
                        newGamePulse <= 1'b1;
                    end else if (start_edge) begin
                        state      <= IDLE;
                        gameActive <= 1'b0;
                        showResult <= 1'b0;
                        winSel     <= SEL_NONE;
                        p1Wins     <= 4'd0;
                        p2Wins     <= 4'd0;
                    end
                end

                default: begin
                    state        <= IDLE;
                    gameActive   <= 1'b0;
                    showResult   <= 1'b0;
                    winSel       <= SEL_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_two_player_match_ctrl.sv
// Purpose: self-checking bench for two_player_match_ctrl; match results go through a scoreboard queue.
// Latency: results are checked when showResult rises, direct checks sample #1 after the clock edge.
// Backpressure: n/a; the bench drives every input from a single stimulus process.
module tb_two_player_match_ctrl;

    localparam int GRACE = 15;
    localparam int SHOW  = 180;
    localparam int SMAX  = 9;

    logic       clk;
    logic       resetN;
    logic       startOfFrame;
    logic       startKey;
    logic       restartKey;
    logic       timeUp;
    logic [3:0] lives;
    logic [3:0] lives2;
    logic       gameActive;
    logic       showResult;
    logic [2:0] winSel;
    logic [3:0] p1Wins;
    logic [3:0] p2Wins;
    logic       newGamePulse;

    two_player_match_ctrl #(
        .LIVES_W      (4),
        .GRACE_FRAMES (GRACE),
        .SHOW_FRAMES  (SHOW),
        .SCORE_MAX    (SMAX)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .startKey     (startKey),
        .restartKey   (restartKey),
        .timeUp       (timeUp),
        .lives        (lives),
        .lives2       (lives2),
        .gameActive   (gameActive),
        .showResult   (showResult),
        .winSel       (winSel),
        .p1Wins       (p1Wins),
        .p2Wins       (p2Wins),
        .newGamePulse (newGamePulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] sel;
        logic [3:0] p1;
        logic [3:0] p2;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   m_p1  = 0;
    int   m_p2  = 0;
    logic prev_show = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            startOfFrame = 1'b1;
            tick();
            startOfFrame = 1'b0;
            tick();
        end
    endtask

    // Reference judgement: push the result the DUT must latch for these lives values.
    task automatic push_judge(input int l1, input int l2);
        exp_t e;
        if (l2 > l1) begin
            e.sel = 3'b001;
            if (m_p2 < SMAX) m_p2++;
        end else if (l1 > l2) begin
            e.sel = 3'b010;
            if (m_p1 < SMAX) m_p1++;
        end else begin
            e.sel = 3'b100;
        end
        e.p1 = 4'(m_p1);
        e.p2 = 4'(m_p2);
        sb.push_back(e);
    endtask

    task automatic restart(input string tag, input logic both_keys);
        restartKey = 1'b1;
        startKey   = both_keys;
        tick();
        check({tag, "_ngp"}, newGamePulse, 1);
        check({tag, "_active"}, gameActive, 1);
        check({tag, "_show"}, showResult, 0);
        check({tag, "_sel"}, winSel, 0);
        check({tag, "_p1kept"}, p1Wins, m_p1);
        restartKey = 1'b0;
        startKey   = 1'b0;
        tick();
        check({tag, "_ngp_1clk"}, newGamePulse, 0);
    endtask

    // Scoreboard monitor: pop an expected result whenever a result screen appears.
    always @(posedge clk) begin
        #2;
        if (showResult && !prev_show) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("res_winSel", winSel, mon_e.sel);
                check("res_p1Wins", p1Wins, mon_e.p1);
                check("res_p2Wins", p2Wins, mon_e.p2);
                check("res_gameActive", gameActive, 0);
            end
        end
        prev_show = showResult;
    end

    initial begin
        resetN       = 1'b0;
        startOfFrame = 1'b0;
        startKey     = 1'b0;
        restartKey   = 1'b0;
        timeUp       = 1'b0;
        lives        = 4'd3;
        lives2       = 4'd2;
        tick();
        tick();
        check("rst_active", gameActive, 0);
        check("rst_show", showResult, 0);
        check("rst_sel", winSel, 0);
        check("rst_p1", p1Wins, 0);
        check("rst_p2", p2Wins, 0);
        check("rst_ngp", newGamePulse, 0);
        resetN = 1'b1;
        tick();

        // Start from menu
        startKey = 1'b1;
        tick();
        check("start_ngp", newGamePulse, 1);
        check("start_active", gameActive, 1);
        check("start_sel", winSel, 0);
        check("start_p1", p1Wins, 0);
        check("start_p2", p2Wins, 0);
        startKey = 1'b0;
        tick();
        check("start_ngp_1clk", newGamePulse, 0);

        // P2 dies: P1 wins after exactly GRACE frames
        lives  = 4'd2;
        lives2 = 4'd0;
        push_judge(2, 0);
        tick();
        frames(GRACE - 1);
        check("grace_edge_show", showResult, 0);
        check("grace_edge_active", gameActive, 1);
        frames(1);
        check("p1win_show", showResult, 1);
        check("p1win_sel", winSel, 3'b010);
        // Lives changes during the result screen are ignored
        lives  = 4'd0;
        lives2 = 4'd5;
        frames(10);
        check("result_sel_stable", winSel, 3'b010);
        check("result_p2_stable", p2Wins, 0);
        frames(SHOW - 10);
        lives  = 4'd3;
        lives2 = 4'd3;
        restart("rs1", 1'b0);

        // P1 dies, recovers (grace not cancelled), then both zero at judge -> draw
        lives = 4'd0;
        tick();
        frames(2);
        lives = 4'd4;
        frames(3);
        check("grace_not_cancel", showResult, 0);
        lives  = 4'd0;
        lives2 = 4'd0;
        push_judge(0, 0);
        frames(GRACE - 5);
        check("draw_sel", winSel, 3'b100);
        frames(SHOW);
        lives  = 4'd1;
        lives2 = 4'd3;
        restart("rs2", 1'b0);

        // Time-up with P2 ahead; restart only accepted after the full show time
        timeUp = 1'b1;
        tick();
        timeUp = 1'b0;
        push_judge(1, 3);
        frames(GRACE);
        check("p2win_sel", winSel, 3'b001);
        frames(100);
        restartKey = 1'b1;
        tick();
        check("early_restart_ngp", newGamePulse, 0);
        check("early_restart_show", showResult, 1);
        restartKey = 1'b0;
        tick();
        frames(SHOW - 101);
        restartKey = 1'b1;
        tick();
        check("last_frame_restart_show", showResult, 1);
        check("last_frame_restart_ngp", newGamePulse, 0);
        restartKey = 1'b0;
        tick();
        frames(1);
        lives  = 4'd3;
        lives2 = 4'd2;
        restart("rs3", 1'b0);

        // Ten P1 wins in a row: counter saturates; one restart uses both keys at once
        for (int k = 0; k < 10; k++) begin
            if (k > 0) begin
                lives2 = 4'd2;
                restart($sformatf("sat%0d", k), (k == 5));
            end
            lives2 = 4'd0;
            push_judge(3, 0);
            tick();
            frames(GRACE + SHOW);
        end
        check("sat_p1", p1Wins, SMAX);
        check("sat_p2", p2Wins, 1);

        // startKey in HOLD returns to menu and clears counters
        startKey = 1'b1;
        tick();
        m_p1 = 0;
        m_p2 = 0;
        check("menu_p1", p1Wins, 0);
        check("menu_p2", p2Wins, 0);
        check("menu_show", showResult, 0);
        check("menu_sel", winSel, 0);
        check("menu_active", gameActive, 0);
        check("menu_ngp", newGamePulse, 0);
        startKey = 1'b0;
        tick();

        // Reset in the middle of a grace window
        lives2   = 4'd2;
        startKey = 1'b1;
        tick();
        startKey = 1'b0;
        tick();
        lives2 = 4'd0;
        tick();
        frames(5);
        #2;
        resetN   = 1'b0;
        startKey = 1'b1;
        #1;
        check("async_rst_active", gameActive, 0);
        check("async_rst_show", showResult, 0);
        check("async_rst_sel", winSel, 0);
        tick();
        tick();
        resetN = 1'b1;
        lives2 = 4'd2;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("held_key_ngp%0d", i), newGamePulse, 0);
            check($sformatf("held_key_active%0d", i), gameActive, 0);
        end
        startKey = 1'b0;
        tick();
        startKey = 1'b1;
        tick();
        check("repress_ngp", newGamePulse, 1);
        check("repress_active", gameActive, 1);
        startKey = 1'b0;
        tick();
        tick();

        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
